// File: rtl/row_mean_seq.sv
// Per-channel frame averager: accumulates N_SAMP columns of N_CH readings, then divides
// every channel sum by N_SAMP on one shared restoring divider and presents the means.
module row_mean_seq #(
   parameter int N_CH   = 8,
   parameter int N_SAMP = 8,
   parameter int N_BITS = 22,
   parameter int ROUND  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] in_col   [N_CH],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_mean [N_CH]
);

   localparam int ACC_W = N_BITS + $clog2(N_SAMP) + 1;
   localparam int CNT_W = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BIT_W = $clog2(ACC_W);

   localparam logic [ACC_W-1:0] BIAS     = (ROUND != 0) ? ACC_W'(N_SAMP / 2) : '0;
   localparam logic [ACC_W-1:0] DIVISOR  = ACC_W'(N_SAMP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMP - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ACC_W - 1);

   typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q  [N_CH];
   logic [ACC_W-1:0]   acc_d  [N_CH];
   logic [N_BITS-1:0]  mean_q [N_CH];
   logic [N_BITS-1:0]  mean_d [N_CH];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [ACC_W-1:0]   rem_q, rem_d;
   logic [ACC_W-1:0]   dq_q, dq_d;

   logic [ACC_W-1:0]   rem_sh, rem_nx, dq_nx, next_div;
   logic               ge;

   // One restoring-division step: dq_q shifts the dividend out at the top and the
   // quotient in at the bottom, so after ACC_W steps it holds the quotient.
   always_comb begin
      rem_sh   = {rem_q[ACC_W-2:0], dq_q[ACC_W-1]};
      ge       = (rem_sh >= DIVISOR);
      rem_nx   = ge ? (rem_sh - DIVISOR) : rem_sh;
      dq_nx    = {dq_q[ACC_W-2:0], ge};
      next_div = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (CH_W'(i) == (ch_q + CH_W'(1))) next_div = acc_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mean_d    = mean_q;
      cnt_d     = cnt_q;
      ch_d      = ch_q;
      bit_d     = bit_q;
      rem_d     = rem_q;
      dq_d      = dq_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               for (int i = 0; i < N_CH; i++) acc_d[i] = acc_q[i] + ACC_W'(in_col[i]);
               if (cnt_q == CNT_LAST) begin
                  // Rounding bias is folded into the sums as the frame closes.
                  for (int i = 0; i < N_CH; i++) acc_d[i] = acc_d[i] + BIAS;
                  cnt_d   = '0;
                  state_d = DIVIDE;
                  dq_d    = acc_d[0];
                  rem_d   = '0;
                  bit_d   = '0;
                  ch_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DIVIDE: begin
            dq_d  = dq_nx;
            rem_d = rem_nx;
            if (bit_q == BIT_LAST) begin
               for (int i = 0; i < N_CH; i++) begin
                  if (CH_W'(i) == ch_q) mean_d[i] = dq_nx[N_BITS-1:0];
               end
               bit_d = '0;
               rem_d = '0;
               if (ch_q == CH_LAST) begin
                  state_d = DONE;
               end else begin
                  ch_d = ch_q + CH_W'(1);
                  dq_d = next_div;
               end
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ACCUM;
               for (int i = 0; i < N_CH; i++) acc_d[i] = '0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         for (int i = 0; i < N_CH; i++) begin
            acc_q[i]  <= '0;
            mean_q[i] <= '0;
         end
         cnt_q <= '0;
         ch_q  <= '0;
         bit_q <= '0;
         rem_q <= '0;
         dq_q  <= '0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < N_CH; i++) begin
            acc_q[i]  <= acc_d[i];
            mean_q[i] <= mean_d[i];
         end
         cnt_q <= cnt_d;
         ch_q  <= ch_d;
         bit_q <= bit_d;
         rem_q <= rem_d;
         dq_q  <= dq_d;
      end
   end

   assign out_mean = mean_q;

endmodule

// File: tb/tb_row_mean_seq.sv
// Randomized and directed frames on three small instances plus one default-parameter
// instance; expected means come from plain integer arithmetic on the applied columns.
module tb_row_mean_seq;

   localparam int ACC = 11;          // 8 + clog2(4 or 3) + 1
   localparam int LAT = 1 + 2 * ACC;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid_ab = 1'b0, out_ready_ab = 1'b0;
   logic       in_valid_c = 1'b0, out_ready_c = 1'b0;
   logic       in_ready_a, in_ready_b, in_ready_c, ov_a, ov_b, ov_c;
   logic [7:0] col    [2];
   logic [7:0] mean_a [2];
   logic [7:0] mean_b [2];
   logic [7:0] mean_c [2];

   logic        in_valid_d = 1'b0, out_ready_d = 1'b0, in_ready_d, ov_d;
   logic [21:0] col_d  [8];
   logic [21:0] mean_dd[8];

   int nvec = 0, nerr = 0;
   int fcol [4][2];
   int pm   [3][2];

   always #5 clk = ~clk;

   row_mean_seq #(.N_CH(2), .N_SAMP(4), .N_BITS(8), .ROUND(0)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_ab), .in_ready(in_ready_a), .in_col(col),
      .out_valid(ov_a), .out_ready(out_ready_ab), .out_mean(mean_a));
   row_mean_seq #(.N_CH(2), .N_SAMP(4), .N_BITS(8), .ROUND(1)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_ab), .in_ready(in_ready_b), .in_col(col),
      .out_valid(ov_b), .out_ready(out_ready_ab), .out_mean(mean_b));
   row_mean_seq #(.N_CH(2), .N_SAMP(3), .N_BITS(8), .ROUND(1)) u_c (
      .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_col(col),
      .out_valid(ov_c), .out_ready(out_ready_c), .out_mean(mean_c));
   row_mean_seq u_d (
      .clk(clk), .reset(reset), .in_valid(in_valid_d), .in_ready(in_ready_d), .in_col(col_d),
      .out_valid(ov_d), .out_ready(out_ready_d), .out_mean(mean_dd));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // inst 0: floor(s/4), inst 1: round-half-up s/4, inst 2: round-half-up s/3
   function automatic int ev(input int inst, input int s);
      case (inst)
         0:       return s / 4;
         1:       return (s + 2) / 4;
         default: return (s + 1) / 3;
      endcase
   endfunction

   function automatic logic [7:0] mv(input int inst, input int ch);
      case (inst)
         0:       return mean_a[ch];
         1:       return mean_b[ch];
         default: return mean_c[ch];
      endcase
   endfunction

   function automatic logic rdy(input int sel);
      return (sel == 0) ? in_ready_a : in_ready_c;
   endfunction

   function automatic logic ovf(input int sel);
      return (sel == 0) ? ov_a : ov_c;
   endfunction

   task automatic set_valid(input int sel, input logic v);
      if (sel == 0) in_valid_ab = v;
      else          in_valid_c  = v;
   endtask

   task automatic set_ord(input int sel, input logic v);
      if (sel == 0) out_ready_ab = v;
      else          out_ready_c  = v;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      in_valid_ab = 1'b0; in_valid_c = 1'b0; in_valid_d = 1'b0;
      out_ready_ab = 1'b0; out_ready_c = 1'b0; out_ready_d = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", {in_ready_a, in_ready_b, in_ready_c, in_ready_d}, 4'hf);
      check("rst_valid", {ov_a, ov_b, ov_c, ov_d}, 4'h0);
      check("rst_mean", {mean_a[0], mean_a[1], mean_b[0], mean_b[1], mean_c[0], mean_c[1]}, 0);
      for (int i = 0; i < 3; i++) begin pm[i][0] = 0; pm[i][1] = 0; end
   endtask

   task automatic run_frame(input int sel, input int maxgap, input int hold,
                            input int abort_col, input int abort_div);
      int ns, n, lo, hi;
      int sum [2];
      int ex  [3][2];
      ns = (sel == 0) ? 4 : 3;
      lo = (sel == 0) ? 0 : 2;
      hi = (sel == 0) ? 1 : 2;
      sum[0] = 0; sum[1] = 0;
      for (int i = 0; i < 3; i++) begin ex[i][0] = 0; ex[i][1] = 0; end
      @(posedge clk); #1;
      for (int k = 0; k < ns; k++) begin
         if (k == abort_col) begin pulse_reset(); return; end
         set_valid(sel, 1'b1);
         col[0] = 8'(fcol[k][0]); col[1] = 8'(fcol[k][1]);
         @(negedge clk);
         check("in_ready", rdy(sel), 1);
         @(posedge clk); #1;
         set_valid(sel, 1'b0);
         col[0] = 8'($urandom); col[1] = 8'($urandom);
         sum[0] += fcol[k][0]; sum[1] += fcol[k][1];
         if (k < ns - 1) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      end
      for (int i = lo; i <= hi; i++) begin
         ex[i][0] = ev(i, sum[0]); ex[i][1] = ev(i, sum[1]);
      end
      set_valid(sel, 1'b1);  // must be ignored while dividing
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == abort_div) begin set_valid(sel, 1'b0); pulse_reset(); return; end
         for (int i = lo; i <= hi; i++) begin
            if (n == ACC) check("ch0_early", mv(i, 0), pm[i][0]);
            if (n == ACC + 1) begin
               check("ch0_done", mv(i, 0), ex[i][0]);
               check("ch1_early", mv(i, 1), pm[i][1]);
            end
         end
         col[0] = 8'($urandom); col[1] = 8'($urandom);
      end while (!ovf(sel) && n < 4 * LAT);
      check("latency", n, LAT);
      if (sel == 0) check("ov_b", ov_b, 1);
      for (int i = lo; i <= hi; i++)
         for (int c = 0; c < 2; c++) check($sformatf("mean%0d_%0d", i, c), mv(i, c), ex[i][c]);
      repeat (hold) begin @(negedge clk); col[0] = 8'($urandom); col[1] = 8'($urandom); end
      if (hold > 0) begin
         check("hold_ready", rdy(sel), 0);
         check("hold_valid", ovf(sel), 1);
         for (int i = lo; i <= hi; i++)
            for (int c = 0; c < 2; c++) check("hold_mean", mv(i, c), ex[i][c]);
      end
      @(posedge clk); #1;
      set_valid(sel, 1'b0);
      set_ord(sel, 1'b1);
      @(posedge clk); #1;
      set_ord(sel, 1'b0);
      @(negedge clk);
      check("post_ready", rdy(sel), 1);
      check("post_valid", ovf(sel), 0);
      for (int i = lo; i <= hi; i++) begin
         check("post_mean", mv(i, 0), ex[i][0]);
         pm[i][0] = ex[i][0]; pm[i][1] = ex[i][1];
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < 2; c++)
            case ($urandom_range(0, 5))
               0:       fcol[k][c] = 255;
               1:       fcol[k][c] = 0;
               default: fcol[k][c] = $urandom_range(0, 255);
            endcase
   endtask

   task automatic run_default();
      int n;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         in_valid_d = 1'b1;
         for (int c = 0; c < 8; c++) col_d[c] = 22'h3fffff;
         @(negedge clk);
         if (k == 0) check("d_ready", in_ready_d, 1);
         @(posedge clk); #1;
         in_valid_d = 1'b0;
         for (int c = 0; c < 8; c++) col_d[c] = 22'($urandom);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!ov_d && n < 1000);
      check("d_latency", n, 209);
      for (int c = 0; c < 8; c++) check("d_mean", mean_dd[c], 4194303);
      @(posedge clk); #1; out_ready_d = 1'b1;
      @(posedge clk); #1; out_ready_d = 1'b0;
      @(negedge clk);
      check("d_post_ready", in_ready_d, 1);
   endtask

   initial begin
      col[0] = '0; col[1] = '0;
      for (int c = 0; c < 8; c++) col_d[c] = '0;
      pulse_reset();
      run_default();
      // two-channel reference frame, long DONE hold with in_valid high
      fcol[0] = '{10, 1}; fcol[1] = '{20, 2}; fcol[2] = '{30, 3}; fcol[3] = '{40, 5};
      run_frame(0, 0, 50, -1, -1);
      // non-power-of-two divisor with rounding, including full-scale inputs
      fcol[0] = '{1, 255}; fcol[1] = '{1, 255}; fcol[2] = '{2, 255};
      run_frame(1, 1, 3, -1, -1);
      // discarded frames: mid-accumulate, then mid-divide, each followed by a clean frame
      fill_random(); run_frame(0, 1, 0, 2, -1);
      fill_random(); run_frame(0, 1, 2, -1, -1);
      fill_random(); run_frame(0, 0, 0, -1, 15);
      fill_random(); run_frame(0, 0, 1, -1, -1);
      fill_random(); run_frame(1, 0, 0, -1, 5);
      fill_random(); run_frame(1, 2, 1, -1, -1);
      for (int r = 0; r < 16; r++) begin
         fill_random();
         run_frame(r % 2, 2, $urandom_range(0, 4), -1, -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
